muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative, parametrised multiply/divide unit implementing the RV M-extension ops at width `XLEN`.
- Sits beside the combinational ALU in the EXU and takes the same A/B operands.
- Accepts one operation at a time over a valid/ready handshake and computes it with a radix-2 shift-add/restoring loop.
- Returns the result over a second valid/ready handshake. Handles signedness, divide-by-zero and signed overflow per the RISC-V spec.

## Interface

- `XLEN`, default 32: operand/result width (≥ 8, even).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit idle, can accept.
- `op` in 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` in XLEN: rs1 operand (multiplicand/dividend).
- `b` in XLEN: rs2 operand (multiplier/divisor).
- `flush` in 1: abort current operation and drop any pending result.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: operation result.

## Operation

- States: IDLE, CALC, DONE.
- `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`.
- IDLE→CALC on `in_valid & in_ready & ~flush`:
  - Latch op, latch |a| and |b| per op signedness, record sign flags.
  - Step counter loads XLEN.
- IDLE→DONE directly (special cases, no iteration):
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → `a`.
  - DIV with a = −2^(XLEN−1), b = −1 → `a`; REM in the same case → 0.
- CALC, multiply:
  - 2·XLEN-bit accumulator; one shift-add per cycle.
  - Signed operands (MULH: both; MULHSU: `a` only) are converted to magnitude. The full 2·XLEN product is negated if the signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- CALC, divide:
  - XLEN-bit restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- CALC→DONE when the counter reaches 0. Sign fix-up is applied on that transition, and `result` is registered.
- DONE→IDLE on `out_ready`. `result` and `out_valid` are held stable while `out_ready` is low.
- `flush` in any state → IDLE on the next edge. No result is produced. `flush` beats `in_valid` in the same cycle, and that request is not accepted.
- Reset (asynchronous, any state): state IDLE, `out_valid` 0, `in_ready` 1 after deassertion, `result` 0, counter 0, accumulators 0.

## Timing

- Request accepted at edge k (normal case):
  - CALC occupies cycles k+1 … k+XLEN.
  - `out_valid` is high from cycle k+XLEN+1. Latency is XLEN+1 cycles, i.e. 33 at XLEN=32.
- Special cases: `out_valid` is high from cycle k+1.
- No back-to-back overlap. The next request can be accepted no earlier than the cycle after the DONE→IDLE handshake edge.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `out_ready`.

## Structure

- Shared header `muldiv_defs.vh` holds the op encodings (`MD_MUL` … `MD_REMU`) and the state encodings, for reuse by the decoder.
- One natural sub-module: `muldiv_signfix`. It is combinational, handles magnitude conversion and conditional two's-complement negation, and is instantiated for the operand and result paths.
- Multiply and divide share the step counter and the FSM. The datapath registers are separate.

## Test plan

- MUL, a=7, b=0xFFFFFFFD (−3) → `result` 0xFFFFFFEB. `out_valid` first high exactly 33 cycles after the accept edge.
- Multiply high variants:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide variants:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM of the same → 0xFFFFFFFF.
  - DIVU 7 / 2 → 3.
  - REMU 7 / 2 → 1.
- Special cases, each with `out_valid` at k+1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same → 0.
- Backpressure: hold `out_ready` low 5 cycles after `out_valid`. `result` is stable, `in_ready` stays 0, and a new `in_valid` is ignored until the handshake completes.
- Abort/reset:
  - `flush` at the 10th CALC cycle: `in_ready` is 1 next cycle and no `out_valid` ever follows.
  - `rst_n` pulse mid-CALC: all outputs return to reset values immediately.
  - A fresh MUL 3×4 afterwards returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV M-extension
// funct3 encodings, FSM state encoding and operand-signedness decode.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic logic op_is_div(md_op_e op);
    return op[2];
  endfunction

  // Only meaningful for divide ops: REM/REMU have funct3[1] set.
  function automatic logic op_is_rem(md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_a_signed(md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the EXU and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  md_op_e          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; yields a magnitude when negate is the
// operand's sign, or applies the final sign to an unsigned result.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);
  assign result = negate ? (~value + W'(1)) : value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV M-extension: one shift-add
// or restoring-subtract step per cycle, XLEN steps per operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int              CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   mcand_q, quo_q, rem_q, dvs_q, result_q;
  logic              neg_q, rem_neg_q;

  logic              accept, a_neg, b_neg, div_zero, div_ovf, special, last;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix, calc_res;

  assign accept   = (state_q == ST_IDLE) && bus.in_valid && !bus.flush;
  assign a_neg    = op_a_signed(bus.op) && bus.a[XLEN-1];
  assign b_neg    = op_b_signed(bus.op) && bus.b[XLEN-1];
  assign div_zero = op_is_div(bus.op) && (bus.b == '0);
  assign div_ovf  = ((bus.op == MD_DIV) || (bus.op == MD_REM)) && (bus.a == MIN_NEG) && (bus.b == '1);
  assign special  = div_zero || div_ovf;
  assign special_res = div_zero ? (op_is_rem(bus.op) ? bus.a : '1)
                                : (op_is_rem(bus.op) ? '0 : bus.a);

  muldiv_signfix #(.W(XLEN)) u_a_mag (.value(bus.a), .negate(a_neg), .result(a_mag));
  muldiv_signfix #(.W(XLEN)) u_b_mag (.value(bus.b), .negate(b_neg), .result(b_mag));

  // Multiply: high half accumulates, low half holds the multiplier shifting out LSB-first.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};

  // Divide: restoring step, quotient bits shift in where dividend bits shift out.
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};
  assign rem_nxt   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign quo_nxt   = {quo_q[XLEN-2:0], ~div_diff[XLEN]};

  muldiv_signfix #(.W(2*XLEN)) u_prod_fix (.value(prod_nxt), .negate(neg_q),     .result(prod_fix));
  muldiv_signfix #(.W(XLEN))   u_quo_fix  (.value(quo_nxt),  .negate(neg_q),     .result(quo_fix));
  muldiv_signfix #(.W(XLEN))   u_rem_fix  (.value(rem_nxt),  .negate(rem_neg_q), .result(rem_fix));

  assign last = (cnt_q == CNT_W'(1));

  always_comb begin
    if (op_is_div(op_q))     calc_res = op_is_rem(op_q) ? rem_fix : quo_fix;
    else if (op_q == MD_MUL) calc_res = prod_fix[XLEN-1:0];
    else                     calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (bus.flush) state_d = ST_IDLE;
               else if (last) state_d = ST_DONE;
      ST_DONE: if (bus.flush || bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: these are flops, not memories, so they are all reset to a known zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MD_MUL;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= bus.op;
      cnt_q     <= special ? '0 : CNT_W'(XLEN);
      prod_q    <= {{XLEN{1'b0}}, b_mag};
      mcand_q   <= a_mag;
      quo_q     <= a_mag;
      rem_q     <= '0;
      dvs_q     <= b_mag;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      if (special) result_q <= special_res;
    end else if (state_q == ST_CALC) begin
      if (bus.flush) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (op_is_div(op_q)) begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
        end else begin
          prod_q <= prod_nxt;
        end
        if (last) result_q <= calc_res;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed M-extension cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    longint      acc_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  bit     rand_rdy = 1'b0;
  bit     rdy_force = 1'b1;
  exp_t   sb_q[$];
  exp_t   mon_e;
  bit     seen = 1'b0;
  logic [31:0] held;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV M-extension definitions.
  function automatic logic [31:0] ref_model(md_op_e op, logic [31:0] a, logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    int          ia = a;
    int          ib = b;
    logic [63:0] p;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                 else return ia / ib;
      MD_REM:    if (b == 0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                 else return ia % ib;
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(md_op_e op, logic [31:0] a, logic [31:0] b);
    return (op_is_div(op) && b == 0) ||
           ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(15));
      default: return $urandom();
    endcase
  endfunction

  // Present a request, wait (bounded) for acceptance, then record its expectation.
  task automatic issue(md_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    exp_t e;
    bit   rdy = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    for (int i = 0; i < 200 && !rdy; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op=%s never accepted", op.name());
      return;
    end
    e.op = op;
    e.a = a;
    e.b = b;
    e.res = exp;
    e.lat = is_special(op, a, b) ? 1 : XLEN + 1;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus.in_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d results still outstanding", sb_q.size());
    sb_q.delete();
  endtask

  // Drives out_ready: randomized during the random phase, otherwise held at rdy_force.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_rdy ? ($urandom_range(3) != 0) : rdy_force;
    end
  end

  // Monitor: latency on first sight, stability while stalled, value on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      check("in_ready_low_while_done", bus.in_ready, 0);
      if (!seen) begin
        seen = 1'b1;
        held = bus.result;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: result 0x%0h with no request pending", bus.result);
        end else begin
          check($sformatf("latency %s", sb_q[0].op.name()), cyc - sb_q[0].acc_cyc + 1, sb_q[0].lat);
        end
      end else begin
        check("result_stable_under_backpressure", bus.result, held);
      end
      if (bus.out_ready) begin
        seen = 1'b0;
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check($sformatf("%s a=0x%h b=0x%h", mon_e.op.name(), mon_e.a, mon_e.b), bus.result, mon_e.res);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    md_op_e      rop;
    logic [31:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.op = MD_MUL;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;

    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_in_ready", bus.in_ready, 1);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);

    issue(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    issue(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    issue(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    issue(MD_DIVU,   32'd7,          32'd2,         32'd3);
    issue(MD_REMU,   32'd7,          32'd2,         32'd1);
    issue(MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
    issue(MD_REM,    32'd5,          32'd0,         32'd5);
    issue(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    issue(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    wait_drain();

    // A request coinciding with flush must be dropped.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.op = MD_MUL;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_beats_in_valid", bus.in_ready, 1);
    repeat (40) @(posedge clk);

    // Backpressure: stall 5 cycles with a competing request that must be ignored.
    rdy_force = 1'b0;
    issue(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    check("bp_out_valid_seen", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op = MD_DIVU;
    bus.a = 32'd100;
    bus.b = 32'd7;
    repeat (5) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_out_valid_held", bus.out_valid, 1);
    check("bp_in_ready_low", bus.in_ready, 0);
    rdy_force = 1'b1;
    wait_drain();
    repeat (40) @(posedge clk);

    // Flush during the 10th CALC cycle.
    issue(MD_MUL, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("in_ready_after_flush", bus.in_ready, 1);
    check("out_valid_after_flush", bus.out_valid, 0);
    repeat (60) @(posedge clk);

    // Asynchronous reset pulse mid-CALC.
    issue(MD_DIV, 32'd1000, 32'd7, 32'h0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_in_ready", bus.in_ready, 1);
    check("async_reset_out_valid", bus.out_valid, 0);
    check("async_reset_result", bus.result, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(MD_MUL, 32'd3, 32'd4, 32'd12);
    wait_drain();

    // Randomized operations with random consumer stalls.
    rand_rdy = 1'b1;
    repeat (150) begin
      rop = md_op_e'($urandom_range(7));
      ra = pick();
      rb = pick();
      issue(rop, ra, rb, ref_model(rop, ra, rb));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
    end
    wait_drain();
    rand_rdy = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
